fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Read-side consumer for the team's FIFO read port (rd / rd_data / empty, show-ahead: rd_data is valid whenever empty is low).
- Pops words from the FIFO and presents them as a valid/ready stream.
- Uses a 2-entry output buffer so the FIFO read strobe never depends combinationally on downstream ready.
- Frames the stream into packets of a runtime-programmable length, with a last flag and a per-packet done pulse.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- LEN_W, 8, width of the packet-length input and the beat counter.

Ports:
- rd_clk  input  1  clock, same domain as FIFO read side.
- rd_rst_n  input  1  asynchronous active-low reset.
- en  input  1  enables popping from the FIFO.
- pkt_len  input  LEN_W  beats per packet; sampled at packet start; 0 treated as 1.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  WIDTH  FIFO head word (show-ahead).
- fifo_rd  output  1  FIFO pop strobe.
- m_data  output  WIDTH  stream data.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready.
- m_last  output  1  final beat of packet, qualified by m_valid.
- pkt_done  output  1  one-cycle pulse, registered, the cycle after the last beat handshake.
- busy  output  1  high while a packet is partially popped or the buffer is non-empty.

Behaviour:
- Clock and reset: one clock, rd_clk. Reset rd_rst_n is asynchronous, active-low.
- Reset values:
  - buffer count 0, head and tail indices 0, entries 0.
  - m_valid 0, m_data 0, m_last 0.
  - pkt_done 0, busy 0.
  - pop beat counter 0, latched length 1.
  - fifo_rd is forced 0 while rd_rst_n is low.
- Pop rule (combinational from registers and inputs only): fifo_rd = en & ~fifo_empty & (count < 2). It never depends on m_ready.
- On a pop edge:
  - fifo_rd_data and a last bit are written into the buffer tail entry.
  - Tail index toggles.
  - Latency: word visible on m_data one cycle after the pop cycle.
- Packet framing on pop side:
  - When the beat counter = 0, latch len_q = (pkt_len == 0) ? 1 : pkt_len.
  - The latched length is used for the sampling cycle itself.
  - Last bit = (beat counter == len_q-1).
  - Beat counter increments on each pop and wraps to 0 after the last beat.
  - pkt_len changes mid-packet are ignored.
- Output side:
  - m_valid = (count != 0); m_data and m_last come from the head entry.
  - Handshake = m_valid & m_ready; it advances head.
  - m_data and m_last hold stable while m_valid & ~m_ready (AXI-style; no retraction).
- Count update:
  - +1 on pop only; -1 on handshake only; unchanged on both or neither.
  - Count never exceeds 2 and never underflows.
- Throughput: with count = 1 and a continuous pop plus handshake, one beat per cycle is sustained.
- pkt_done: registered pulse, asserted the cycle after a handshake with m_last = 1.
- busy = (count != 0) | (beat counter != 0).
- en deassertion:
  - Stops further pops immediately, mid-packet included.
  - Buffered words still drain; the beat counter is preserved; framing resumes when en returns.
- FIFO empty mid-packet: popping stalls; m_valid drops once the buffer drains; the packet continues when data arrives.
- Reset mid-packet:
  - All state clears at once and buffered words are discarded.
  - The next word after reset starts a new packet.

Decomposition:
- Package fifo_pkg:
  - constant FIFO_RD_BUF_DEPTH = 2.
  - function to normalise a zero length to 1.
  - shared with the FIFO for the show-ahead contract.
- Sub-module stream_buf2:
  - 2-entry register buffer, WIDTH+1 wide, carrying {last, data}.
  - Ports: push, push_data, m_valid/m_ready/m_data, count.
  - Reused for other stream sources.
- Top-level holds the pop logic, beat counter, length latch, pkt_done and busy.

Test Plan:
- Reset with en=1 and fifo_empty=0 -> fifo_rd=0 and m_valid=0 during reset; after release, first pop next cycle and m_valid=1 one cycle later.
- pkt_len=4, FIFO holding 0x10..0x17, m_ready=1 -> fifo_rd high 8 consecutive cycles; m_data 0x10..0x17 one beat per cycle; m_last on 0x13 and 0x17; pkt_done pulses the cycle after each.
- m_ready=0 with FIFO non-empty -> exactly 2 pops, then fifo_rd=0; m_data holds the first word; on m_ready=1 words drain in order with none lost or duplicated.
- pkt_len=0 -> every beat has m_last=1; pkt_len changed from 3 to 5 after beat 1 -> current packet still ends at beat 3, next packet is 5 beats.
- en dropped after beat 2 of a 4-beat packet -> buffered words drain, busy stays 1; en restored -> beats 3-4 follow, last on beat 4.
- Reset asserted with count=2 mid-packet -> m_valid=0 and busy=0 immediately; the next packet's first word is framed as beat 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side contract (show-ahead head word,
// two-deep read buffer) used by the FIFO and its stream readers.
package fifo_pkg;

  localparam int unsigned FIFO_RD_BUF_DEPTH = 2;
  localparam int unsigned BUF_CNT_W         = $clog2(FIFO_RD_BUF_DEPTH + 1);

  // A programmed length of zero means a single-beat packet.
  function automatic int unsigned norm_len(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry register buffer presenting pushed words as a valid/ready stream.
// The push side never looks at m_ready, so upstream strobes stay registered-only.
module stream_buf2
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic [BUF_CNT_W-1:0] count
);

  logic [WIDTH-1:0]     ent_q [FIFO_RD_BUF_DEPTH];
  logic                 head_q;
  logic                 head_d;
  logic                 tail_q;
  logic                 tail_d;
  logic [BUF_CNT_W-1:0] count_q;
  logic [BUF_CNT_W-1:0] count_d;
  logic                 accept;
  logic                 take;

  // A push into a full buffer is dropped rather than overwriting the head.
  assign accept = push & (count_q < BUF_CNT_W'(FIFO_RD_BUF_DEPTH));
  assign take   = (count_q != '0) & m_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case ({accept, take})
      2'b10:   count_d = count_q + BUF_CNT_W'(1);
      2'b01:   count_d = count_q - BUF_CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (accept) tail_d = ~tail_q;
    if (take)   head_d = ~head_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      for (int unsigned i = 0; i < FIFO_RD_BUF_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (accept) ent_q[tail_q] <= push_data;
    end
  end

  assign m_valid = (count_q != '0);
  assign m_data  = ent_q[head_q];
  assign count   = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a show-ahead FIFO into a buffered valid/ready stream and frames the
// words into packets of a runtime-programmable length.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic             rd_clk,
  input  logic             rd_rst_n,
  input  logic             en,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             pkt_done,
  output logic             busy
);

  logic [BUF_CNT_W-1:0] count;
  logic [WIDTH:0]       buf_out;
  logic [LEN_W-1:0]     beat_q;
  logic [LEN_W-1:0]     beat_d;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     len_d;
  logic [LEN_W-1:0]     len_eff;
  logic                 last_bit;
  logic                 pkt_done_q;
  logic                 pkt_done_d;

  // Reset gates the strobe so the FIFO never loses a word while we are held.
  assign fifo_rd = rd_rst_n & en & ~fifo_empty & (count < BUF_CNT_W'(FIFO_RD_BUF_DEPTH));

  // At a packet boundary the live pkt_len frames the very beat being popped.
  always_comb begin
    len_eff    = (beat_q == '0) ? LEN_W'(norm_len(32'(pkt_len))) : len_q;
    last_bit   = (beat_q == len_eff - LEN_W'(1));
    len_d      = len_eff;
    beat_d     = beat_q;
    if (fifo_rd) beat_d = last_bit ? '0 : beat_q + LEN_W'(1);
    pkt_done_d = m_valid & m_ready & m_last;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      beat_q     <= '0;
      len_q      <= LEN_W'(1);
      pkt_done_q <= 1'b0;
    end else begin
      beat_q     <= beat_d;
      len_q      <= len_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  stream_buf2 #(
    .WIDTH(WIDTH + 1)
  ) u_buf (
    .clk      (rd_clk),
    .rst_n    (rd_rst_n),
    .push     (fifo_rd),
    .push_data({last_bit, fifo_rd_data}),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (buf_out),
    .count    (count)
  );

  assign m_data   = buf_out[WIDTH-1:0];
  assign m_last   = buf_out[WIDTH];
  assign pkt_done = pkt_done_q;
  assign busy     = (count != '0) | (beat_q != '0);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a queue-based FIFO and packet model
// predicts pops and framed words; a separate monitor checks the output stream.
module tb_fifo_stream_reader;

  localparam int unsigned W  = 8;
  localparam int unsigned LW = 8;

  logic          rd_clk       = 1'b0;
  logic          rd_rst_n     = 1'b0;
  logic          en           = 1'b0;
  logic [LW-1:0] pkt_len      = 8'd1;
  logic          fifo_empty   = 1'b1;
  logic [W-1:0]  fifo_rd_data = '0;
  logic          m_ready      = 1'b0;
  logic          fifo_rd;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_last;
  logic          pkt_done;
  logic          busy;

  int errors = 0;
  int checks = 0;

  logic [W:0]   exp_q [$];   // {last, data} in stream order
  logic [W-1:0] fq    [$];   // FIFO contents, head at index 0
  int           model_beat = 0;
  int           model_len  = 1;
  bit           starve     = 1'b0;
  bit           done_exp   = 1'b0;

  fifo_stream_reader #(
    .WIDTH(W),
    .LEN_W(LW)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst_n    (rd_rst_n),
    .en          (en),
    .pkt_len     (pkt_len),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd     (fifo_rd),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .pkt_done    (pkt_done),
    .busy        (busy)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle, entered at a falling edge: drive, predict, record the pop, wait.
  task automatic step();
    logic exp_rd;
    logic last;
    fifo_empty   = (fq.size() == 0) || starve;
    fifo_rd_data = (fq.size() != 0) ? fq[0] : '0;
    #1;
    chk("m_valid", m_valid, exp_q.size() != 0);
    chk("busy", busy, (exp_q.size() != 0) || (model_beat != 0));
    exp_rd = en && !fifo_empty && (exp_q.size() < 2);
    chk("fifo_rd", fifo_rd, exp_rd);
    if (fifo_rd === 1'b1 && !fifo_empty) begin
      if (model_beat == 0) model_len = (pkt_len == 0) ? 1 : int'(pkt_len);
      last = (model_beat + 1 == model_len);
      exp_q.push_back({last, fq[0]});
      void'(fq.pop_front());
      model_beat = last ? 0 : model_beat + 1;
    end
    @(negedge rd_clk);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) fq.push_back(W'($urandom));
  endtask

  task automatic sync_pkt();
    for (int i = 0; i < 40 && model_beat != 0; i++) begin
      if (fq.size() < 2) fill(4);
      step();
    end
    chk("sync_timeout", model_beat, 0);
  endtask

  task automatic reset_mid();
    rd_rst_n   = 1'b0;
    fifo_empty = (fq.size() == 0);
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fifo_rd", fifo_rd, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    exp_q.delete();
    model_beat = 0;
    model_len  = 1;
    @(negedge rd_clk);
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
  endtask

  // Monitor: checks head word whenever valid, consumes on handshake.
  initial begin
    logic [W:0] head;
    forever begin
      @(negedge rd_clk);
      #2;
      if (!rd_rst_n) begin
        done_exp = 1'b0;
        continue;
      end
      chk("pkt_done", pkt_done, done_exp);
      done_exp = 1'b0;
      if (m_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", m_valid, 1'b0);
        end else begin
          head = exp_q[0];
          chk("m_data", m_data, head[W-1:0]);
          chk("m_last", m_last, head[W]);
          if (m_ready) begin
            done_exp = head[W];
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Held in reset with a ready FIFO: nothing may be popped or presented.
    en           = 1'b1;
    pkt_len      = 8'd1;
    fq.push_back(8'hA5);
    fifo_empty   = 1'b0;
    fifo_rd_data = 8'hA5;
    m_ready      = 1'b1;
    @(negedge rd_clk);
    #1;
    chk("reset_fifo_rd", fifo_rd, 1'b0);
    chk("reset_m_valid", m_valid, 1'b0);
    chk("reset_m_data", m_data, 8'h00);
    chk("reset_m_last", m_last, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_pkt_done", pkt_done, 1'b0);
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    repeat (4) step();

    // Two 4-beat packets streamed back to back.
    pkt_len = 8'd4;
    for (int i = 0; i < 8; i++) fq.push_back(W'(8'h10 + i));
    repeat (10) step();

    // Backpressure: only two pops, then in-order drain.
    for (int i = 0; i < 16; i++) fq.push_back(W'(8'h20 + i));
    m_ready = 1'b0;
    repeat (6) step();
    m_ready = 1'b1;
    repeat (20) step();

    // Zero length means single-beat packets.
    pkt_len = 8'd0;
    fill(6);
    repeat (8) step();

    // Length change mid-packet only affects the following packet.
    pkt_len = 8'd3;
    fill(12);
    for (int i = 0; i < 20 && model_beat != 1; i++) step();
    chk("len_change_sync", model_beat, 1);
    pkt_len = 8'd5;
    repeat (14) step();

    // en dropped mid-packet: drain, stay busy, then resume framing.
    sync_pkt();
    pkt_len = 8'd4;
    fill(8);
    for (int i = 0; i < 20 && model_beat != 2; i++) step();
    chk("en_drop_sync", model_beat, 2);
    en = 1'b0;
    repeat (5) step();
    en = 1'b1;
    repeat (8) step();

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      en      = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 9) < 7);
      starve  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) pkt_len = LW'($urandom_range(0, 6));
      while (fq.size() < 3) fq.push_back(W'($urandom));
      step();
    end
    starve = 1'b0;

    // Reset with a full buffer mid-packet.
    en      = 1'b1;
    m_ready = 1'b0;
    pkt_len = 8'd4;
    sync_pkt();
    m_ready = 1'b0;
    fill(8);
    repeat (4) step();
    reset_mid();
    m_ready = 1'b1;
    repeat (10) step();

    // Drain everything outstanding.
    en = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    chk("drain_empty", exp_q.size(), 0);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
